// File: rtl/oc8051_xram_pkg.sv
// Shared definitions for the XRAM guard: FSM encoding, bus widths and the CPU accesser ID.
package oc8051_xram_pkg;
    localparam int XRAM_ADDR_W = 16;
    localparam int XRAM_DATA_W = 8;
    localparam logic [2:0] CPU_ID = 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MEM,
        ST_REG,
        ST_RESP
    } state_t;
endpackage

// File: rtl/oc8051_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module oc8051_rr_arb #(
    parameter int NUM_MST = 4,
    localparam int IDX_W = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_MST-1:0] grant,
    output logic [IDX_W-1:0]   idx
);
    int j;
    logic [IDX_W-1:0] k;

    always_comb begin
        grant = '0;
        idx   = '0;
        j     = 0;
        k     = '0;
        // Scan from the farthest slot down so the closest requester overwrites last.
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_MST) j = j - NUM_MST;
            k = IDX_W'(j);
            if (req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end
endmodule

// File: rtl/oc8051_xram_guard.sv
// XRAM access guard: arbitrates masters, asks the page-table checker for a verdict,
// then routes to XRAM or the PT/IA register windows, or completes locally with an error.
module oc8051_xram_guard
    import oc8051_xram_pkg::*;
#(
    parameter int NUM_MST = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MST-1:0]             mst_req,
    input  logic [NUM_MST-1:0]             mst_wr,
    input  logic [XRAM_ADDR_W*NUM_MST-1:0] mst_addr,
    input  logic [XRAM_DATA_W*NUM_MST-1:0] mst_wdata,
    output logic [NUM_MST-1:0]             mst_ack,
    output logic [XRAM_DATA_W-1:0]         mst_rdata,
    output logic                           mst_err,
    output logic [XRAM_ADDR_W-1:0]         xram_addr,
    output logic [XRAM_DATA_W-1:0]         xram_data_in,
    output logic                           xram_wr,
    output logic                           xram_stb,
    output logic [2:0]                     accesser,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic                           pt_addr_range,
    input  logic                           ia_addr_range,
    output logic                           pt_stb,
    input  logic                           pt_ack,
    input  logic [XRAM_DATA_W-1:0]         pt_data_out,
    output logic                           ia_stb,
    input  logic                           ia_ack,
    input  logic [XRAM_DATA_W-1:0]         ia_data_out,
    output logic                           mem_stb,
    input  logic                           mem_ack,
    input  logic [XRAM_DATA_W-1:0]         mem_rdata
);
    localparam int IDX_W = $clog2(NUM_MST);

    state_t                 state;
    logic [IDX_W-1:0]       ptr;
    logic [7:0]             cnt;
    logic                   reg_pt;
    logic                   err_q;
    logic [XRAM_DATA_W-1:0] rdata_q;

    logic [NUM_MST-1:0]     grant;
    logic [IDX_W-1:0]       gidx;
    logic [XRAM_ADDR_W-1:0] sel_addr;
    logic [XRAM_DATA_W-1:0] sel_wdata;
    logic                   sel_wr;
    logic                   in_window;

    oc8051_rr_arb #(.NUM_MST(NUM_MST)) u_arb (
        .req   (mst_req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant[i]) begin
                sel_addr  = mst_addr[XRAM_ADDR_W*i +: XRAM_ADDR_W];
                sel_wdata = mst_wdata[XRAM_DATA_W*i +: XRAM_DATA_W];
                sel_wr    = mst_wr[i];
            end
        end
    end

    assign in_window = pt_addr_range | ia_addr_range;

    // Strobes decode straight from state so an async reset drops them at once.
    assign xram_stb  = (state == ST_CHECK) && !in_window;
    assign mem_stb   = (state == ST_MEM);
    assign pt_stb    = (state == ST_REG) && reg_pt;
    assign ia_stb    = (state == ST_REG) && !reg_pt;
    assign mst_rdata = (state == ST_RESP) ? rdata_q : '0;
    assign mst_err   = (state == ST_RESP) && err_q;

    always_comb begin
        mst_ack = '0;
        for (int i = 0; i < NUM_MST; i++)
            mst_ack[i] = (state == ST_RESP) && (accesser == 3'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            cnt          <= '0;
            reg_pt       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            xram_addr    <= '0;
            xram_data_in <= '0;
            xram_wr      <= 1'b0;
            accesser     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (|mst_req) begin
                    xram_addr    <= sel_addr;
                    xram_data_in <= sel_wdata;
                    xram_wr      <= sel_wr;
                    accesser     <= 3'(gidx);
                    state        <= ST_CHECK;
                end
                ST_CHECK: begin
                    cnt <= '0;
                    if (in_window && accesser == CPU_ID) begin
                        reg_pt <= pt_addr_range;
                        state  <= ST_REG;
                    end else if (!in_window && (xram_wr ? wr_en : rd_en)) begin
                        state <= ST_MEM;
                    end else begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_RESP;
                    end
                end
                ST_MEM: begin
                    // An ack on the timeout cycle still wins.
                    if (mem_ack) begin
                        err_q   <= 1'b0;
                        rdata_q <= xram_wr ? '0 : mem_rdata;
                        state   <= ST_RESP;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_REG: begin
                    if (reg_pt ? pt_ack : ia_ack) begin
                        err_q   <= 1'b0;
                        rdata_q <= reg_pt ? pt_data_out : ia_data_out;
                        state   <= ST_RESP;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (accesser == 3'(NUM_MST - 1)) ptr <= '0;
                    else                             ptr <= IDX_W'(accesser) + IDX_W'(1);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oc8051_xram_guard.sv
// Scoreboard bench for oc8051_xram_guard: directed transactions push expected
// completions; a monitor pops and compares on every mst_ack.
module tb_oc8051_xram_guard;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mst_req, mst_wr, mst_ack;
    logic [63:0] mst_addr;
    logic [31:0] mst_wdata;
    logic [7:0]  mst_rdata, xram_data_in, pt_data_out, ia_data_out, mem_rdata;
    logic        mst_err, xram_wr, xram_stb, wr_en, rd_en, pt_addr_range, ia_addr_range;
    logic        pt_stb, pt_ack, ia_stb, ia_ack, mem_stb, mem_ack;
    logic [15:0] xram_addr;
    logic [2:0]  accesser;

    typedef struct {
        int       id;
        logic [7:0] rdata;
        logic     err;
        int       at;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0, n_err = 0, cyc = 0, n_excl = 0;
    int n_xstb = 0, n_mstb = 0, n_pstb = 0, n_istb = 0;
    logic [2:0]  last_acc;
    logic [7:0]  last_wdata;
    logic        last_wr;
    int          mem_en = 1, rsp_delay = 0;

    oc8051_xram_guard #(.NUM_MST(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .mst_req(mst_req), .mst_wr(mst_wr), .mst_addr(mst_addr),
        .mst_wdata(mst_wdata), .mst_ack(mst_ack), .mst_rdata(mst_rdata), .mst_err(mst_err),
        .xram_addr(xram_addr), .xram_data_in(xram_data_in), .xram_wr(xram_wr),
        .xram_stb(xram_stb), .accesser(accesser), .wr_en(wr_en), .rd_en(rd_en),
        .pt_addr_range(pt_addr_range), .ia_addr_range(ia_addr_range), .pt_stb(pt_stb),
        .pt_ack(pt_ack), .pt_data_out(pt_data_out), .ia_stb(ia_stb), .ia_ack(ia_ack),
        .ia_data_out(ia_data_out), .mem_stb(mem_stb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Checker / memory model: PT window 0xFF80-0xFF8F, IA window 0xFF90-0xFF9F.
    assign pt_addr_range = (xram_addr[15:4] == 12'hFF8);
    assign ia_addr_range = (xram_addr[15:4] == 12'hFF9);
    assign mem_rdata     = xram_addr[7:0] ^ 8'h91;
    assign pt_data_out   = 8'h3C;
    assign ia_data_out   = 8'hC3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responders ack once a strobe has been seen for more than rsp_delay cycles.
    initial begin
        int mc, pc, ic;
        mc = 0; pc = 0; ic = 0;
        mem_ack = 1'b0; pt_ack = 1'b0; ia_ack = 1'b0;
        forever begin
            @(negedge clk);
            mc = mem_stb ? mc + 1 : 0;
            pc = pt_stb  ? pc + 1 : 0;
            ic = ia_stb  ? ic + 1 : 0;
            mem_ack = mem_stb && (mem_en != 0) && (mc > rsp_delay);
            pt_ack  = pt_stb && (pc > rsp_delay);
            ia_ack  = ia_stb && (ic > rsp_delay);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (xram_stb) begin
                n_xstb++; last_acc = accesser; last_wdata = xram_data_in; last_wr = xram_wr;
            end
            if (mem_stb) n_mstb++;
            if (pt_stb)  n_pstb++;
            if (ia_stb)  n_istb++;
            if (int'(xram_stb) + int'(mem_stb) + int'(pt_stb) + int'(ia_stb) > 1) n_excl++;
            if (!$onehot0(mst_ack)) n_excl++;
        end
    end

    initial begin
        exp_t e;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (rst && |mst_ack) begin
                if (q.size() == 0) chk("unexpected_ack", 64'(mst_ack), 64'd0);
                else begin
                    e  = q.pop_front();
                    oh = 4'b0001 << e.id;
                    chk("ack_id", 64'(mst_ack), 64'(oh));
                    chk("ack_rdata", 64'(mst_rdata), 64'(e.rdata));
                    chk("ack_err", 64'(mst_err), 64'(e.err));
                    if (e.at >= 0) chk("ack_cycle", 64'(cyc), 64'(e.at));
                end
            end
        end
    end

    function automatic logic [63:0] outs();
        return 64'({mst_ack, mst_err, mst_rdata, xram_addr, xram_data_in, xram_wr,
                    xram_stb, accesser, pt_stb, ia_stb, mem_stb});
    endfunction

    task automatic set_mst(input int m, input bit wr, input logic [15:0] addr, input logic [7:0] wd);
        mst_wr[m] = wr;
        mst_addr[16*m +: 16] = addr;
        mst_wdata[8*m +: 8] = wd;
        mst_req[m] = 1'b1;
    endtask

    task automatic push(input int m, input logic [7:0] rd, input logic err, input int at);
        exp_t e;
        e.id = m; e.rdata = rd; e.err = err; e.at = at;
        q.push_back(e);
    endtask

    // One transaction from master m; expects its ack lat cycles after issue.
    task automatic txn(input int m, input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                       input logic [7:0] rd, input logic err, input int lat);
        int n;
        @(negedge clk);
        set_mst(m, wr, addr, wd);
        push(m, rd, err, cyc + lat);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mst_ack[m] && n < 400);
        if (!mst_ack[m]) chk("ack_timeout", 64'(n), 64'd0);
        mst_req[m] = 1'b0;
    endtask

    task automatic wait_acks(input int cnt, input logic [3:0] drop);
        int got, n;
        got = 0; n = 0;
        while (got < cnt && n < 400) begin
            @(negedge clk);
            n++;
            if (|mst_ack) begin
                got++;
                mst_req = mst_req & ~(mst_ack & drop);
            end
        end
        if (got < cnt) chk("ack_timeout", 64'(got), 64'(cnt));
    endtask

    initial begin
        int b_x, b_m, b_p, b_i, c0, n;
        rst = 1'b0; mst_req = '0; mst_wr = '0; mst_addr = '0; mst_wdata = '0;
        wr_en = 1'b1; rd_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        rst = 1'b1;

        // Continuous requests from 0, 1, 3: grant order 0,1,3,0,1,3, one idle between.
        @(negedge clk);
        rsp_delay = 0;
        c0 = cyc;
        set_mst(0, 1'b0, 16'h1010, 8'h00);
        set_mst(1, 1'b0, 16'h2020, 8'h00);
        set_mst(3, 1'b0, 16'h3030, 8'h00);
        push(0, 8'h81, 1'b0, c0 + 3);
        push(1, 8'hB1, 1'b0, c0 + 7);
        push(3, 8'hA1, 1'b0, c0 + 11);
        push(0, 8'h81, 1'b0, c0 + 15);
        push(1, 8'hB1, 1'b0, c0 + 19);
        push(3, 8'hA1, 1'b0, c0 + 23);
        wait_acks(6, 4'b0000);
        mst_req = '0;

        // CPU read, memory acks one cycle after mem_stb rises.
        rsp_delay = 1;
        b_x = n_xstb; b_m = n_mstb;
        txn(0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 4);
        chk("t1_xram_stb_pulses", 64'(n_xstb - b_x), 64'd1);
        chk("t1_mem_stb_cycles", 64'(n_mstb - b_m), 64'd2);

        // Master 2 write denied by checker.
        wr_en = 1'b0;
        b_x = n_xstb; b_m = n_mstb;
        txn(2, 1'b1, 16'h4000, 8'h77, 8'h00, 1'b1, 2);
        chk("t2_xram_stb_pulses", 64'(n_xstb - b_x), 64'd1);
        chk("t2_accesser", 64'(last_acc), 64'd2);
        chk("t2_xram_wr", 64'(last_wr), 64'd1);
        chk("t2_xram_data_in", 64'(last_wdata), 64'h77);
        chk("t2_no_mem_stb", 64'(n_mstb - b_m), 64'd0);
        wr_en = 1'b1;

        // Register windows: non-CPU rejected, CPU reaches PT and IA registers.
        b_x = n_xstb; b_p = n_pstb;
        txn(1, 1'b0, 16'hFF85, 8'h00, 8'h00, 1'b1, 2);
        chk("t4_noncpu_no_pt_stb", 64'(n_pstb - b_p), 64'd0);
        chk("t4_noncpu_no_xram_stb", 64'(n_xstb - b_x), 64'd0);
        b_p = n_pstb;
        txn(0, 1'b0, 16'hFF85, 8'h00, 8'h3C, 1'b0, 4);
        chk("t4_pt_stb_cycles", 64'(n_pstb - b_p), 64'd2);
        rsp_delay = 0;
        b_i = n_istb;
        txn(0, 1'b0, 16'hFF92, 8'h00, 8'hC3, 1'b0, 3);
        chk("t4_ia_stb_cycles", 64'(n_istb - b_i), 64'd1);

        // Memory never acks: 255 MEM cycles then an error completion.
        mem_en = 0;
        b_m = n_mstb;
        txn(1, 1'b0, 16'h0500, 8'h00, 8'h00, 1'b1, 257);
        chk("t5_mem_stb_cycles", 64'(n_mstb - b_m), 64'd255);

        // Reset mid-transaction from master 3, then restart with pointer 0.
        @(negedge clk);
        set_mst(3, 1'b0, 16'h0611, 8'h00);
        n = 0;
        while (!mem_stb && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t6_mem_stb_seen", 64'(mem_stb), 64'd1);
        #2 rst = 1'b0;
        #1 chk("t6_async_reset_outputs", outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_en = 1;
        c0 = cyc;
        set_mst(1, 1'b0, 16'h0700, 8'h00);
        push(1, 8'h91, 1'b0, c0 + 3);
        push(3, 8'h80, 1'b0, c0 + 7);
        wait_acks(2, 4'b1111);
        mst_req = '0;

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("exclusivity", 64'(n_excl), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
